// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB master bridge and its bench monitors.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    localparam int APB_TIMEOUT_DEFAULT = 256;

endpackage : apb_master_pkg

// File: rtl/apb_intf.sv
// APB bus bundle: the master drives the address/control/write-data side and
// the responder returns read data, ready and slave error.
interface apb_intf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface : apb_intf

// File: rtl/apb_master_bridge.sv
// APB initiator: turns one valid/ready request at a time into an APB
// SETUP/ACCESS transfer and returns read data plus error/timeout status on a
// valid/ready response channel. Every output comes straight from a flop.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = APB_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    apb_intf.master           apb_intf
);

    // Wide enough to hold TIMEOUT; kept at one bit when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    apb_mst_state_e    state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next-state and next-output logic; every register holds unless its state says otherwise.
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    paddr_d     = req_addr;
                    pwrite_d    = req_write;
                    pwdata_d    = req_write ? req_wdata : '0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    req_ready_d = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (apb_intf.pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : apb_intf.prdata;
                    rsp_err_d     = apb_intf.pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    cnt_d         = '0;
                    state_d       = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    cnt_d         = '0;
                    state_d       = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; async reset drops the bus and discards any response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign rsp_err          = rsp_err_q;
    assign rsp_timeout      = rsp_timeout_q;
    assign apb_intf.psel    = psel_q;
    assign apb_intf.penable = penable_q;
    assign apb_intf.pwrite  = pwrite_q;
    assign apb_intf.paddr   = paddr_q;
    assign apb_intf.pwdata  = pwdata_q;

endmodule : apb_master_bridge

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a programmable APB responder model,
// expected responses queued at request time and popped at the response handshake.
module tb_apb_master_bridge;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int TMO    = 8;
    localparam int BOUND  = 40;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;

    int            slave_waits = 0;
    bit            slave_hang = 1'b0;
    logic [DW-1:0] slave_rdata = '0;
    logic          slave_err = 1'b0;
    int            acc_cnt = 0;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    apb_intf #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .apb_intf    (bus)
    );

    always #5 clk = ~clk;

    // Responder model: ready after slave_waits stalled ACCESS cycles, never when hung.
    always @(posedge clk) begin
        acc_cnt <= (bus.psel && bus.penable && !bus.pready) ? acc_cnt + 1 : 0;
    end

    assign bus.pready  = bus.psel && bus.penable && !slave_hang && (acc_cnt >= slave_waits);
    assign bus.prdata  = (bus.pready && !bus.pwrite) ? slave_rdata : 32'hDEAD_BEEF;
    assign bus.pslverr = bus.pready ? slave_err : 1'b1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One full transfer: request, APB phase checks, held response, scoreboard pop.
    task automatic apply_stimulus(input logic wr, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wdata, input logic [DW-1:0] sdata,
                                  input logic serr, input int waits, input bit hang,
                                  input int hold, input bit keep_valid);
        logic [DW-1:0] exp_pw;
        exp_t          e;
        int            n;
        int            lat;
        int            acc;
        bit            stable_ok;
        exp_pw      = wr ? wdata : '0;
        slave_waits = waits;
        slave_hang  = hang;
        slave_rdata = sdata;
        slave_err   = serr;
        e.rdata = (wr || hang) ? '0 : sdata;
        e.err   = hang ? 1'b1 : serr;
        e.tmo   = hang;
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check_output("req_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        if (!keep_valid) req_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        check_output("setup_psel_penable", {30'd0, bus.psel, bus.penable}, 32'd2);
        check_output("setup_paddr", bus.paddr, addr);
        check_output("setup_pwdata", bus.pwdata, exp_pw);
        check_output("setup_pwrite", {31'd0, bus.pwrite}, {31'd0, wr});
        acc = 0;
        stable_ok = 1'b1;
        while (lat < BOUND) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
            if (bus.psel && bus.penable) acc++;
            if (bus.paddr !== addr || bus.pwdata !== exp_pw || bus.pwrite !== wr) stable_ok = 1'b0;
        end
        check_output("rsp_latency", lat, hang ? 3 + TMO - 1 : 3 + waits);
        check_output("access_cycles", acc, hang ? TMO : waits + 1);
        check_output("apb_fields_stable", {31'd0, stable_ok}, 32'd1);
        check_output("resp_psel_penable", {30'd0, bus.psel, bus.penable}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            check_output("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check_output("hold_req_ready", {31'd0, req_ready}, 32'd0);
            check_output("hold_rdata", rsp_rdata, e.rdata);
            check_output("hold_psel", {31'd0, bus.psel}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        e = exp_q.pop_front();
        check_output("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_output("rsp_rdata", rsp_rdata, e.rdata);
        check_output("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check_output("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.tmo});
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check_output("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_output("post_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    // Safety net so the run always ends even if the DUT wedges a wait loop.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence: reset, the scenarios in order, then the summary line.
    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_psel_penable_pwrite", {29'd0, bus.psel, bus.penable, bus.pwrite}, 32'd0);
        check_output("rst_paddr", bus.paddr, 32'd0);
        check_output("rst_pwdata", bus.pwdata, 32'd0);
        check_output("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_output("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
        check_output("rst_rsp_rdata", rsp_rdata, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check_output("idle_req_ready", {31'd0, req_ready}, 32'd1);

        $display("[TB] zero-wait write");
        apply_stimulus(1'b1, 32'h004, 32'h0000_8000, 32'h0, 1'b0, 0, 1'b0, 0, 1'b0);
        $display("[TB] zero-wait read");
        apply_stimulus(1'b0, 32'h008, 32'hFFFF_FFFF, 32'h2000_0000, 1'b0, 0, 1'b0, 0, 1'b0);
        $display("[TB] five wait states then slave error");
        apply_stimulus(1'b1, 32'h00C, 32'hA5A5_1234, 32'h0, 1'b1, 5, 1'b0, 0, 1'b0);
        $display("[TB] hung slave timeout");
        apply_stimulus(1'b0, 32'h010, 32'h0, 32'h1111_2222, 1'b0, 0, 1'b1, 0, 1'b0);
        $display("[TB] read after timeout");
        apply_stimulus(1'b0, 32'h014, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 1'b0, 0, 1'b0);
        $display("[TB] back-to-back with held response");
        apply_stimulus(1'b1, 32'h018, 32'h0BAD_BEEF, 32'h0, 1'b0, 0, 1'b0, 4, 1'b1);
        apply_stimulus(1'b0, 32'h01C, 32'h0, 32'h7654_3210, 1'b0, 1, 1'b0, 0, 1'b0);

        $display("[TB] reset during ACCESS");
        slave_hang = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h020;
        req_wdata  = 32'h1234_5678;
        n = 0;
        while (!req_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("mid_access_penable", {30'd0, bus.psel, bus.penable}, 32'd3);
        #2;
        rstn = 1'b0;
        #1;
        check_output("async_rst_bus", {30'd0, bus.psel, bus.penable}, 32'd0);
        check_output("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        slave_hang = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_output("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid || bus.psel) n++;
        end
        check_output("no_spurious_rsp", n, 32'd0);
        rsp_ready = 1'b0;
        apply_stimulus(1'b0, 32'h024, 32'h0, 32'h5A5A_A5A5, 1'b0, 0, 1'b0, 0, 1'b0);

        check_output("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_apb_master_bridge
